// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared types and constants for the 5-stage MIPS pipeline control.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } pipe_state_e;

  localparam logic [4:0] REG_ZERO          = 5'd0;
  localparam logic [5:0] OPCODE_HALT       = 6'h3F;
  localparam int         DRAIN_CYCLES_DFLT = 3;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Brief    : Decode/hazard observation fields and pipeline-register controls.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;

  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic       i_id_uses_rt;
  logic       i_ex_mem_read;
  logic [4:0] i_ex_rt;
  logic       i_branch_taken;
  logic       i_halt_instr;
  logic       o_pipe_en;
  logic       o_pc_we;
  logic       o_if_id_we;
  logic       o_if_id_flush;
  logic       o_id_ex_bubble;

  // Core datapath side: publishes decode fields, consumes controls.
  modport master (
    output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rt,
           i_branch_taken, i_halt_instr,
    input  o_pipe_en, o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rt,
           i_branch_taken, i_halt_instr,
    output o_pipe_en, o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use hazard compare between EX load and ID.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
  import mips_pkg::*;
(
  input  wire logic       ex_mem_read_i,
  input  wire logic [4:0] ex_rt_i,
  input  wire logic [4:0] id_rs_i,
  input  wire logic [4:0] id_rt_i,
  input  wire logic       id_uses_rt_i,
  output logic            stall_o
);

  // $zero is never a real dependency, so a load targeting it cannot stall.
  assign stall_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                   ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Run/step/halt sequencer and hazard controller for the pipeline.
//            Optional stall counter output enabled by PIPELINE_CTRL_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import mips_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DFLT,
  parameter int CNT_W        = 32
) (
  input  wire logic             clk,
  input  wire logic             i_rst,
  input  wire logic             i_start,
  input  wire logic             i_step,
  input  wire logic             i_halt_req,
  pipeline_ctrl_if.slave        pif,
  output logic                  o_halted,
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  output logic [CNT_W-1:0]      o_stall_cnt,
`endif
  output logic [CNT_W-1:0]      o_cycle_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pipe_state_e      state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cycle_q;
  logic             stall;
  logic             pipe_en;

  hazard_detect u_hazard (
    .ex_mem_read_i (pif.i_ex_mem_read),
    .ex_rt_i       (pif.i_ex_rt),
    .id_rs_i       (pif.i_id_rs),
    .id_rt_i       (pif.i_id_rt),
    .id_uses_rt_i  (pif.i_id_uses_rt),
    .stall_o       (stall)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (pipe_en && (cycle_q != '1))
        cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d            = state_q;
    drain_d            = drain_q;
    pipe_en            = 1'b0;
    pif.o_pc_we        = 1'b0;
    pif.o_if_id_we     = 1'b0;
    pif.o_if_id_flush  = 1'b0;
    pif.o_id_ex_bubble = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start)     state_d = ST_RUN;
        else if (i_step) state_d = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        pipe_en = 1'b1;
        // A HALT stuck behind a load has not really left ID yet.
        if (pif.i_halt_instr && !stall) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else if ((state_q == ST_STEP) || i_halt_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        pipe_en = 1'b1;
        if (drain_q == '0) state_d = ST_HALTED;
        else               drain_d = drain_q - DW'(1);
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    if (state_q == ST_DRAIN) begin
      pif.o_if_id_we     = 1'b1;
      pif.o_if_id_flush  = 1'b1;
      pif.o_id_ex_bubble = 1'b1;
    end else if (pipe_en) begin
      if (stall) begin
        pif.o_id_ex_bubble = 1'b1;
      end else begin
        pif.o_pc_we       = 1'b1;
        pif.o_if_id_we    = 1'b1;
        pif.o_if_id_flush = pif.i_branch_taken;
      end
    end
  end

  assign pif.o_pipe_en = pipe_en;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_cycle_cnt   = cycle_q;

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (i_rst)
      stall_cnt_q <= '0;
    else if (pipe_en && stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
